// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: memory port arbitration between
// IF and MEM, per-register StallBus codes, stale-fetch tracking and counters.
module pipeline_stall_ctrl #(
    parameter int CNT_W   = 32,
    parameter int FLUSH_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic               mem_req,
    input  logic               mem_done,
    input  logic               id_load_use,
    input  logic               ex_branch_error,
    output logic               grant_if,
    output logic               grant_mem,
    output logic [1:0]         stall_pc,
    output logic [1:0]         stall_if_id,
    output logic [1:0]         stall_id_ex,
    output logic [1:0]         stall_ex_mem,
    output logic [1:0]         stall_mem_wb,
    output logic               fetch_discard,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [FLUSH_W-1:0] flush_count
);

    // state   | meaning
    // IDLE    | memory port free; next owner picked here (MEM first)
    // IF_OWN  | instruction fetch owns the port until mem_done
    // MEM_OWN | MEM stage owns the port until mem_done
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_OWN  = 2'b01,
        MEM_OWN = 2'b10
    } arb_state_t;

    localparam logic [1:0] PASS = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;
    localparam logic [1:0] BUBB = 2'b10;

    arb_state_t state, state_next;
    logic       redirect_pending;
    logic       mem_stall;
    logic       if_stall;
    logic       branch_accept;

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Arbiter next state; every access is followed by one IDLE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_req)     state_next = MEM_OWN;
                else if (if_req) state_next = IF_OWN;
            end
            IF_OWN:  if (mem_done) state_next = IDLE;
            MEM_OWN: if (mem_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_if  = (state == IF_OWN);
    assign grant_mem = (state == MEM_OWN);

    // Hazard decode and StallBus priority; reset forces everything to Pass.
    always_comb begin
        mem_stall     = mem_req & ~((state == MEM_OWN) & mem_done);
        if_stall      = if_req  & ~((state == IF_OWN)  & mem_done);
        branch_accept = 1'b0;
        fetch_discard = 1'b0;
        stall_pc      = PASS;
        stall_if_id   = PASS;
        stall_id_ex   = PASS;
        stall_ex_mem  = PASS;
        stall_mem_wb  = PASS;
        if (rst) begin
            fetch_discard = redirect_pending & (state == IF_OWN) & mem_done;
            if (mem_stall) begin
                stall_pc     = HOLD;
                stall_if_id  = HOLD;
                stall_id_ex  = HOLD;
                stall_ex_mem = HOLD;
                stall_mem_wb = BUBB;
            end else if (ex_branch_error) begin
                branch_accept = 1'b1;
                stall_if_id   = BUBB;
                stall_id_ex   = BUBB;
            end else if (id_load_use) begin
                stall_pc    = HOLD;
                stall_if_id = HOLD;
                stall_id_ex = BUBB;
            end else if (if_stall || fetch_discard) begin
                stall_pc    = HOLD;
                stall_if_id = BUBB;
            end
        end
    end

    // Remember a redirect that lands while a fetch is still outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            redirect_pending <= 1'b0;
        else if (fetch_discard)
            redirect_pending <= 1'b0;
        else if (branch_accept && (state == IF_OWN) && !mem_done)
            redirect_pending <= 1'b1;
    end

    // Saturating stall-cycle and flush counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((stall_pc != PASS) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (branch_accept && (flush_count != '1))
                flush_count <= flush_count + FLUSH_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: arbitration, stall priority,
// stale-fetch discard and counter saturation (on a narrow second instance).
module tb_pipeline_stall_ctrl;

    localparam logic [1:0] P = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic if_req = 0, mem_req = 0, mem_done = 0, id_load_use = 0, ex_branch_error = 0;
    logic grant_if, grant_mem, fetch_discard;
    logic [1:0] stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    logic s_if_req = 0, s_branch = 0;
    logic s_grant_if, s_grant_mem, s_fetch_discard;
    logic [1:0] s_pc, s_if_id, s_id_ex, s_ex_mem, s_mem_wb;
    logic [1:0] s_stall_cycles, s_flush_count;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk(clk), .rst(rst), .if_req(if_req), .mem_req(mem_req), .mem_done(mem_done),
        .id_load_use(id_load_use), .ex_branch_error(ex_branch_error),
        .grant_if(grant_if), .grant_mem(grant_mem),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .fetch_discard(fetch_discard), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_stall_ctrl #(.CNT_W(2), .FLUSH_W(2)) dut_sat (
        .clk(clk), .rst(rst), .if_req(s_if_req), .mem_req(1'b0), .mem_done(1'b0),
        .id_load_use(1'b0), .ex_branch_error(s_branch),
        .grant_if(s_grant_if), .grant_mem(s_grant_mem),
        .stall_pc(s_pc), .stall_if_id(s_if_id), .stall_id_ex(s_id_ex),
        .stall_ex_mem(s_ex_mem), .stall_mem_wb(s_mem_wb),
        .fetch_discard(s_fetch_discard), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Compare the five StallBus codes {pc, if_id, id_ex, ex_mem, mem_wb}.
    task automatic st(input string name, input logic [9:0] exp);
        chk(name, {22'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb}, {22'd0, exp});
    endtask

    task automatic grants(input string name, input logic gi, input logic gm);
        chk(name, {30'd0, grant_if, grant_mem}, {30'd0, gi, gm});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // A: leave reset, IF requests
        step(); rst = 1; if_req = 1; #1;
        st("a_if_stall", {H, B, P, P, P});
        grants("a_grants_idle", 0, 0);
        // B: IF_OWN, MEM requests, then async reset mid-access
        step(); mem_req = 1; #1;
        grants("b_grant_if", 1, 0);
        st("b_mem_stall", {H, H, H, H, B});
        rst = 0; #1;
        grants("b_rst_grants", 0, 0);
        st("b_rst_stalls", {P, P, P, P, P});
        chk("b_rst_discard", {31'd0, fetch_discard}, 32'd0);
        chk("b_rst_stall_cycles", stall_cycles, 32'd0);
        chk("b_rst_flush", {16'd0, flush_count}, 32'd0);
        // C: release with both requests pending -> IDLE, MEM wins
        step(); rst = 1; #1;
        grants("c_idle_after_rst", 0, 0);
        st("c_mem_stall_idle", {H, H, H, H, B});
        step(); #1;
        grants("d_grant_mem", 0, 1);
        st("d_mem_stall", {H, H, H, H, B});
        chk("d_stall_cycles", stall_cycles, 32'd1);
        // E: MEM access completes
        step(); mem_done = 1; #1;
        st("e_done_if_stall", {H, B, P, P, P});
        chk("e_stall_cycles", stall_cycles, 32'd2);
        // F: mandatory IDLE gap
        step(); mem_req = 0; mem_done = 0; #1;
        grants("f_idle_gap", 0, 0);
        chk("f_stall_cycles", stall_cycles, 32'd3);
        // G: IF owns port, branch pulse during fetch
        step(); ex_branch_error = 1; #1;
        grants("g_grant_if", 1, 0);
        st("g_branch", {P, B, B, P, P});
        chk("g_stall_cycles", stall_cycles, 32'd4);
        step(); ex_branch_error = 0; #1;
        st("h_if_stall", {H, B, P, P, P});
        chk("h_flush", {16'd0, flush_count}, 32'd1);
        chk("h_no_discard", {31'd0, fetch_discard}, 32'd0);
        step(); #1;
        chk("i_no_discard", {31'd0, fetch_discard}, 32'd0);
        // J: stale fetch completes
        step(); mem_done = 1; #1;
        chk("j_discard", {31'd0, fetch_discard}, 32'd1);
        st("j_discard_stalls", {H, B, P, P, P});
        chk("j_stall_cycles", stall_cycles, 32'd6);
        // K/L: next fetch is not discarded
        step(); mem_done = 0; #1;
        chk("k_discard_clear", {31'd0, fetch_discard}, 32'd0);
        grants("k_idle", 0, 0);
        step(); mem_done = 1; #1;
        grants("l_grant_if", 1, 0);
        chk("l_no_discard", {31'd0, fetch_discard}, 32'd0);
        st("l_all_pass", {P, P, P, P, P});
        chk("l_stall_cycles", stall_cycles, 32'd8);
        // M: load-use alone
        step(); if_req = 0; mem_done = 0; id_load_use = 1; #1;
        st("m_load_use", {H, H, B, P, P});
        chk("m_stall_cycles", stall_cycles, 32'd8);
        // N: mem_done in IDLE is ignored
        step(); id_load_use = 0; mem_done = 1; #1;
        st("n_all_pass", {P, P, P, P, P});
        chk("n_stall_cycles", stall_cycles, 32'd9);
        // O: branch during mem stall is ignored
        step(); mem_done = 0; mem_req = 1; ex_branch_error = 1; #1;
        grants("o_still_idle", 0, 0);
        st("o_branch_masked", {H, H, H, H, B});
        step(); #1;
        grants("p_grant_mem", 0, 1);
        st("p_branch_masked", {H, H, H, H, B});
        chk("p_flush_unchanged", {16'd0, flush_count}, 32'd1);
        // Q: mem_done with branch still high -> branch accepted
        step(); mem_done = 1; #1;
        st("q_branch_accept", {P, B, B, P, P});
        step(); mem_req = 0; mem_done = 0; ex_branch_error = 0; #1;
        chk("r_flush", {16'd0, flush_count}, 32'd2);
        chk("r_stall_cycles", stall_cycles, 32'd11);
        st("r_all_pass", {P, P, P, P, P});
        chk("r_no_discard", {31'd0, fetch_discard}, 32'd0);
        // Saturation on the 2-bit instance
        step(); s_if_req = 1; #1;
        chk("s_sat_start", {30'd0, s_stall_cycles}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(); #1;
            chk($sformatf("s_sat_stall_%0d", i), {30'd0, s_stall_cycles}, (i > 3) ? 32'd3 : 32'(i));
        end
        s_branch = 1;
        for (int i = 1; i <= 5; i++) begin
            step(); #1;
            chk($sformatf("s_sat_flush_%0d", i), {30'd0, s_flush_count}, (i > 3) ? 32'd3 : 32'(i));
        end
        chk("s_sat_stall_hold", {30'd0, s_stall_cycles}, 32'd3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core. It drives the `StallBus` code (Pass/Hold/Bubb) of the PC and of every pipeline register: if_id, id_ex, ex_mem, mem_wb.
It also arbitrates the single memory port between instruction fetch (IF) and the MEM stage. It tracks redirects that arrive while a fetch is in flight.
Sits beside the pipeline registers; consumes hazard/branch/memory status from ID, EX and the memory controller.

Parameters:
CNT_W, 32, width of the saturating stall-cycle counter
FLUSH_W, 16, width of the saturating flush counter

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-low reset
if_req  input  1  IF needs the memory port (held until served)
mem_req  input  1  MEM stage needs the memory port (held until served)
mem_done  input  1  memory controller finished current access (1-cycle pulse)
id_load_use  input  1  ID detected load-use hazard
ex_branch_error  input  1  EX detected misprediction/redirect
grant_if  output  1  memory port owned by IF
grant_mem  output  1  memory port owned by MEM
stall_pc  output  2  StallBus code for PC
stall_if_id  output  2  StallBus code for if_id
stall_id_ex  output  2  StallBus code for id_ex
stall_ex_mem  output  2  StallBus code for ex_mem
stall_mem_wb  output  2  StallBus code for mem_wb
fetch_discard  output  1  the fetch completing this cycle is stale; drop it
stall_cycles  output  CNT_W  cycles with stall_pc != Pass
flush_count  output  FLUSH_W  number of branch_error cycles accepted

Behaviour:
- StallBus codes: Pass=2'b00 (load), Hold=2'b01 (keep), Bubb=2'b10 (clear to zero).
- Reset (rst=0, async): arbiter state IDLE, grant_if=grant_mem=0, redirect_pending=0, counters=0.
  - All stall outputs = Pass and fetch_discard=0 while in reset.
  - Reset mid-access abandons the access; no state survives.
- Arbiter FSM (registered), states IDLE, IF_OWN, MEM_OWN:
  - IDLE: mem_req -> MEM_OWN; else if_req -> IF_OWN; else stay. MEM has priority.
  - IF_OWN / MEM_OWN: stay until mem_done, then -> IDLE. One IDLE cycle is always inserted between accesses; requesters drop req the cycle after mem_done.
  - grant_if = (state==IF_OWN); grant_mem = (state==MEM_OWN). Both are registered state decodes, never both 1.
- Derived conditions (combinational from state and inputs):
  - mem_stall = mem_req & !(state==MEM_OWN & mem_done)
  - if_stall = if_req & !(state==IF_OWN & mem_done)
- Stall outputs are combinational from state and inputs, so they take effect the same cycle. Priority, highest first:
  1. mem_stall: pc, if_id, id_ex, ex_mem = Hold; mem_wb = Bubb. ex_branch_error and id_load_use are ignored this cycle; they are re-presented by the held stages.
  2. ex_branch_error: pc = Pass (redirect); if_id = Bubb; id_ex = Bubb; ex_mem = Pass; mem_wb = Pass.
  3. id_load_use: pc = Hold; if_id = Hold; id_ex = Bubb; ex_mem = Pass; mem_wb = Pass.
  4. if_stall: pc = Hold; if_id = Bubb; others = Pass.
  5. Otherwise all Pass.
- Redirect tracking:
  - redirect_pending is set on the clock edge where ex_branch_error is accepted (case 2 above) while state==IF_OWN and mem_done=0.
  - fetch_discard = redirect_pending & state==IF_OWN & mem_done. In that cycle if_id is forced to Bubb and pc to Hold, overriding case 5 only.
  - redirect_pending clears on that edge.
  - A second branch_error while already pending keeps the flag at 1 (no counting).
- Counters:
  - stall_cycles increments every cycle with stall_pc != Pass.
  - flush_count increments on each accepted ex_branch_error cycle (case 2).
  - Both saturate at all-ones; no wrap.
- mem_done with no owner (state IDLE) is ignored.

Test Plan:
- Reset: assert rst=0 mid IF_OWN with mem_req=1 -> grants 0, all stall outputs 2'b00, counters 0. Release -> IDLE; next cycle grant_mem=1.
- Contention: if_req=mem_req=1 in IDLE -> grant_mem=1 next cycle; stall_mem_wb=2'b10 and the upper stages 2'b01 until mem_done. After mem_done -> one IDLE cycle, then grant_if=1.
- Load-use: id_load_use=1 for 1 cycle, no other requests -> stall_pc=stall_if_id=2'b01, stall_id_ex=2'b10, stall_cycles increments by 1.
- Branch during mem stall: ex_branch_error=1 with mem_stall=1 -> outputs follow the mem_stall pattern and flush_count is unchanged. When mem_done arrives with branch_error still high -> stall_if_id=stall_id_ex=2'b10 and flush_count=1.
- Stale fetch: IF_OWN, ex_branch_error pulse, mem_done 3 cycles later -> fetch_discard=1 for exactly that cycle with stall_if_id=2'b10; redirect_pending then clears.
- Saturation: preload stall_cycles=32'hFFFF_FFFE, hold if_req without grant for 3 cycles -> stall_cycles stays at 32'hFFFF_FFFF.
